// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with a registered-read or first-word-fall-through
// output stage, occupancy-derived status flags and sticky overflow/underflow errors.
module sync_fifo #(
  parameter int DATA_SIZE = 32,
  parameter int MEM_SIZE  = 32,
  parameter int ADDR_LEN  = 5,
  parameter int FWFT      = 0,
  parameter int AF_LEVEL  = MEM_SIZE - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  w_en,
  input  logic [DATA_SIZE-1:0]  w_data,
  input  logic                  r_en,
  input  logic                  clr_err,
  output logic [DATA_SIZE-1:0]  r_data,
  output logic                  r_valid,
  output logic                  w_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_LEN:0]     count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_LEN:0]   DEPTH_C    = (ADDR_LEN + 1)'(MEM_SIZE);
  localparam logic [ADDR_LEN:0]   AF_C       = (ADDR_LEN + 1)'(AF_LEVEL);
  localparam logic [ADDR_LEN:0]   AE_C       = (ADDR_LEN + 1)'(AE_LEVEL);
  localparam logic [ADDR_LEN:0]   CNT_ZERO_C = {(ADDR_LEN + 1){1'b0}};
  localparam logic [ADDR_LEN:0]   CNT_ONE_C  = {{ADDR_LEN{1'b0}}, 1'b1};
  localparam logic [ADDR_LEN-1:0] PTR_ZERO_C = {ADDR_LEN{1'b0}};
  localparam logic [ADDR_LEN-1:0] PTR_ONE_C  = {{(ADDR_LEN - 1){1'b0}}, 1'b1};

  // Storage is intentionally never reset; only pointers and count define contents.
  logic [DATA_SIZE-1:0] mem_r [MEM_SIZE];

  logic [ADDR_LEN-1:0] wr_ptr_r;
  logic [ADDR_LEN-1:0] rd_ptr_r;
  logic [ADDR_LEN:0]   count_r;
  logic [ADDR_LEN:0]   count_nxt_s;
  logic                w_valid_r;
  logic                overflow_r;
  logic                underflow_r;
  logic                full_s;
  logic                empty_s;
  logic                wr_acc_s;
  logic                rd_acc_s;

  // Status flags come from the registered count; acceptance uses pre-edge flags only.
  always_comb begin
    full_s   = (count_r == DEPTH_C);
    empty_s  = (count_r == CNT_ZERO_C);
    wr_acc_s = w_en & ~full_s;
    rd_acc_s = r_en & ~empty_s;
  end

  // Next occupancy: a simultaneous accepted read and write leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE_C;
      2'b01:   count_nxt_s = count_r - CNT_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy state; pointers wrap naturally at MEM_SIZE (power of two).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r <= count_nxt_s;
    end
  end

  // Storage write port; dropped writes leave the array untouched.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= w_data;
    end
  end

  // Write acknowledge pulse and sticky error flags (set wins over clear).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_valid_r   <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      w_valid_r <= wr_acc_s;
      if (w_en && full_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (r_en && empty_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented continuously while the FIFO holds data.
      always_comb begin
        r_data  = mem_r[rd_ptr_r];
        r_valid = ~empty_s;
      end
    end else begin : g_regread
      logic [DATA_SIZE-1:0] r_data_r;
      logic                 r_valid_r;

      // Registered read: data lands the cycle after an accepted read and then holds.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_data_r  <= {DATA_SIZE{1'b0}};
          r_valid_r <= 1'b0;
        end else begin
          r_valid_r <= rd_acc_s;
          if (rd_acc_s) begin
            r_data_r <= mem_r[rd_ptr_r];
          end
        end
      end

      // Expose the registered read stage.
      always_comb begin
        r_data  = r_data_r;
        r_valid = r_valid_r;
      end
    end
  endgenerate

  // Drive remaining outputs from registered state.
  always_comb begin
    w_valid      = w_valid_r;
    full         = full_s;
    empty        = empty_s;
    almost_full  = (count_r >= AF_C);
    almost_empty = (count_r <= AE_C);
    count        = count_r;
    overflow     = overflow_r;
    underflow    = underflow_r;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one registered-read instance and one FWFT instance,
// both 4 deep x 8 bits; read data is checked by scoreboard monitors.
module tb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // Registered-read instance
  logic       w_en, r_en, clr_err;
  logic [7:0] w_data, r_data;
  logic       r_valid, w_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  // FWFT instance
  logic       f_w_en, f_r_en, f_clr_err;
  logic [7:0] f_w_data, f_r_data;
  logic       f_r_valid, f_w_valid, f_full, f_empty, f_almost_full, f_almost_empty;
  logic       f_overflow, f_underflow;
  logic [2:0] f_count;

  sync_fifo #(.DATA_SIZE(8), .MEM_SIZE(4), .ADDR_LEN(2), .FWFT(0)) dut (
    .clk(clk), .resetn(resetn), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .clr_err(clr_err), .r_data(r_data), .r_valid(r_valid), .w_valid(w_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(.DATA_SIZE(8), .MEM_SIZE(4), .ADDR_LEN(2), .FWFT(1), .AE_LEVEL(1)) dut_f (
    .clk(clk), .resetn(resetn), .w_en(f_w_en), .w_data(f_w_data), .r_en(f_r_en),
    .clr_err(f_clr_err), .r_data(f_r_data), .r_valid(f_r_valid), .w_valid(f_w_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
    .underflow(f_underflow)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_fq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered-read scoreboard: every r_valid beat must match the oldest expected word.
  always @(negedge clk) begin
    if (resetn === 1'b1 && r_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_r_valid: got r_data=%0h expected no valid beat at %0t", r_data, $time);
      end else begin
        check("r_data", {24'd0, r_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // FWFT scoreboard: the word presented while r_en is high is the one popped.
  always @(negedge clk) begin
    if (resetn === 1'b1 && f_r_en === 1'b1) begin
      if (exp_fq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fwft_unexpected_pop: got r_valid=%0b r_data=%0h expected no pop", f_r_valid, f_r_data);
      end else begin
        check("fwft_r_valid_at_pop", {31'd0, f_r_valid}, 32'd1);
        check("fwft_r_data", {24'd0, f_r_data}, {24'd0, exp_fq.pop_front()});
      end
    end
  end

  task automatic op(input logic w, input logic [7:0] d, input logic r, input logic c);
    w_en = w; w_data = d; r_en = r; clr_err = c;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    op(1'b1, d, 1'b0, 1'b0);
    check("w_valid_after_write", {31'd0, w_valid}, 32'd1);
  endtask

  task automatic rd(input logic [7:0] e);
    exp_q.push_back(e);
    op(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic op_f(input logic w, input logic [7:0] d, input logic r);
    f_w_en = w; f_w_data = d; f_r_en = r;
    @(posedge clk); #1;
    f_w_en = 1'b0; f_r_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; w_data = 8'h00;
    f_w_en = 1'b0; f_r_en = 1'b0; f_clr_err = 1'b0; f_w_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_almost_empty", {31'd0, almost_empty}, 32'd1);
    check("rst_almost_full", {31'd0, almost_full}, 32'd0);
    check("rst_r_valid", {31'd0, r_valid}, 32'd0);
    check("rst_w_valid", {31'd0, w_valid}, 32'd0);
    check("rst_r_data", {24'd0, r_data}, 32'd0);
    check("rst_errors", {30'd0, overflow, underflow}, 32'd0);
    check("rst_fwft_r_valid", {31'd0, f_r_valid}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Basic ordering
    wr(8'h11); wr(8'h22); wr(8'h33);
    check("order_count3", {29'd0, count}, 32'd3);
    check("order_almost_full", {31'd0, almost_full}, 32'd1);
    check("order_almost_empty", {31'd0, almost_empty}, 32'd0);
    rd(8'h11);
    check("order_r_valid_next_cycle", {31'd0, r_valid}, 32'd1);
    check("order_count2", {29'd0, count}, 32'd2);
    rd(8'h22); rd(8'h33);
    check("order_empty", {31'd0, empty}, 32'd1);
    op(1'b0, 8'h00, 1'b0, 1'b0);
    check("order_r_valid_drops", {31'd0, r_valid}, 32'd0);
    check("order_r_data_holds", {24'd0, r_data}, 32'h33);
    check("order_all_seen", exp_q.size(), 32'd0);

    // Fill and overflow
    wr(8'hA0); wr(8'hA1); wr(8'hA2);
    check("fill_not_full_at3", {31'd0, full}, 32'd0);
    wr(8'hA3);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count4", {29'd0, count}, 32'd4);
    op(1'b1, 8'hA4, 1'b0, 1'b0);
    check("ovf_w_valid_dropped", {31'd0, w_valid}, 32'd0);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_count4", {29'd0, count}, 32'd4);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Simultaneous read and write at full: read wins, write dropped
    exp_q.push_back(8'hA0);
    op(1'b1, 8'hEE, 1'b1, 1'b0);
    check("simfull_count3", {29'd0, count}, 32'd3);
    check("simfull_overflow", {31'd0, overflow}, 32'd1);
    check("simfull_w_valid", {31'd0, w_valid}, 32'd0);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    check("simfull_clr", {31'd0, overflow}, 32'd0);
    rd(8'hA1); rd(8'hA2); rd(8'hA3);
    op(1'b0, 8'h00, 1'b0, 1'b0);
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_all_seen", exp_q.size(), 32'd0);
    check("drain_no_underflow", {31'd0, underflow}, 32'd0);

    // Underflow, set-over-clear priority, simultaneous access at empty
    op(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_flag", {31'd0, underflow}, 32'd1);
    check("unf_no_r_valid", {31'd0, r_valid}, 32'd0);
    op(1'b0, 8'h00, 1'b1, 1'b1);
    check("unf_set_beats_clr", {31'd0, underflow}, 32'd1);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_cleared", {31'd0, underflow}, 32'd0);
    op(1'b1, 8'h77, 1'b1, 1'b0);
    check("simempty_count1", {29'd0, count}, 32'd1);
    check("simempty_underflow", {31'd0, underflow}, 32'd1);
    check("simempty_w_valid", {31'd0, w_valid}, 32'd1);
    check("simempty_no_r_valid", {31'd0, r_valid}, 32'd0);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    rd(8'h77);

    // Wrap-around with interleaved pairs
    for (int i = 0; i < 10; i++) begin
      wr(8'(i));
      check("wrap_count_after_write", {29'd0, count}, 32'd1);
      rd(8'(i));
      check("wrap_count_after_read", {29'd0, count}, 32'd0);
    end
    op(1'b0, 8'h00, 1'b0, 1'b0);
    check("wrap_all_seen", exp_q.size(), 32'd0);

    // Reset mid-operation while a read beat is on the output
    wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    check("midrst_count3_before", {29'd0, count}, 32'd3);
    #2 resetn = 1'b0;
    #1;
    check("midrst_count0", {29'd0, count}, 32'd0);
    check("midrst_empty", {31'd0, empty}, 32'd1);
    check("midrst_r_valid0", {31'd0, r_valid}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    op(1'b0, 8'h00, 1'b1, 1'b0);
    check("postrst_underflow", {31'd0, underflow}, 32'd1);
    check("postrst_no_r_valid", {31'd0, r_valid}, 32'd0);

    // FWFT mode and almost_empty threshold of 1
    op_f(1'b1, 8'h5A, 1'b0);
    check("fwft_r_valid_no_ren", {31'd0, f_r_valid}, 32'd1);
    check("fwft_r_data_head", {24'd0, f_r_data}, 32'h5A);
    check("fwft_w_valid", {31'd0, f_w_valid}, 32'd1);
    check("fwft_ae_at1", {31'd0, f_almost_empty}, 32'd1);
    op_f(1'b1, 8'h6B, 1'b0);
    check("fwft_ae_at2", {31'd0, f_almost_empty}, 32'd0);
    check("fwft_head_stable", {24'd0, f_r_data}, 32'h5A);
    exp_fq.push_back(8'h5A);
    op_f(1'b0, 8'h00, 1'b1);
    check("fwft_next_word", {24'd0, f_r_data}, 32'h6B);
    check("fwft_count1", {29'd0, f_count}, 32'd1);
    exp_fq.push_back(8'h6B);
    op_f(1'b0, 8'h00, 1'b1);
    check("fwft_empty_r_valid", {31'd0, f_r_valid}, 32'd0);
    check("fwft_empty", {31'd0, f_empty}, 32'd1);
    check("fwft_all_popped", exp_fq.size(), 32'd0);
    check("regread_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
